// File: rtl/psum_acc_ctrl.sv
// -----------------------------------------------------------------------------
// psum_acc_ctrl
//   Sequencer for the two-stage, 3-row psum adder tree of the conv kernel.
//   It admits PE-row beats into the tree, steers the tree's psum input (zero,
//   or the bias, for the first input channel of a pixel, and the tree's own
//   output for later channels), and captures each finished pixel sum into a
//   valid/ready result register. A job covers cfg_npix pixels of
//   max(cfg_ich,1) input channels each and ends with a one-cycle done pulse.
//
//   Optional build macro: PSUM_ACC_CTRL_BIAS_EN adds i_cfg_bias, which is
//   latched at start and used as the first-channel psum instead of zero.
//
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_start              one-cycle job start (ignored unless idle)
//   i_cfg_ich            input channels per pixel (0 is treated as 1)
//   i_cfg_npix           output pixels per job (0 finishes immediately)
//   i_cfg_bias           first-channel psum (only with PSUM_ACC_CTRL_BIAS_EN)
//   o_busy, o_done       job in progress / one-cycle job-end pulse
//   i_pe_valid           PE rows present a beat
//   o_pe_ready           beat accepted this cycle when i_pe_valid is high
//   i_tree_psum_out      adder tree output (LAT cycles after its input)
//   o_tree_psum_in       psum driven into the adder tree
//   o_res_valid          pixel result available
//   i_res_ready          downstream accepts the result
//   o_res_data           pixel result (stable while o_res_valid is high)
// -----------------------------------------------------------------------------
module psum_acc_ctrl #(
  parameter int DWIDTH = 25,
  parameter int CH_W   = 8,
  parameter int PIX_W  = 16,
  parameter int LAT    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [CH_W-1:0]   i_cfg_ich,
  input  logic [PIX_W-1:0]  i_cfg_npix,
`ifdef PSUM_ACC_CTRL_BIAS_EN
  input  logic [DWIDTH-1:0] i_cfg_bias,
`endif
  output logic              o_busy,
  output logic              o_done,
  input  logic              i_pe_valid,
  output logic              o_pe_ready,
  input  logic [DWIDTH-1:0] i_tree_psum_out,
  output logic [DWIDTH-1:0] o_tree_psum_in,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [DWIDTH-1:0] o_res_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CH_W-1:0]  CH_ONE  = {{(CH_W-1){1'b0}}, 1'b1};
  localparam logic [PIX_W-1:0] PIX_ONE = {{(PIX_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next_state;
  logic [CH_W-1:0]     r_ich;
  logic [PIX_W-1:0]    r_npix;
  logic [CH_W-1:0]     r_ch_cnt;
  logic [PIX_W-1:0]    r_pix_cnt;
  // Bit k is set k+1 cycles after an accept; the top bit marks the cycle in
  // which the tree output holds that beat's sum.
  logic [LAT-1:0]      r_vld_sr;
  logic [LAT-1:0]      r_last_sr;
  logic                r_res_valid;
  logic [DWIDTH-1:0]   r_res_data;
  logic                r_busy;
  logic                r_done;

  logic                w_start_job;
  logic                w_is_last;
  logic                w_is_last_pix;
  logic                w_spacing_ok;
  logic                w_slot_ok;
  logic                w_pe_ready;
  logic                w_accept;
  logic                w_capture;
  logic                w_res_hs;
  logic [DWIDTH-1:0]   w_first_psum;

`ifdef PSUM_ACC_CTRL_BIAS_EN
  logic [DWIDTH-1:0]   r_bias;
  assign w_first_psum = r_bias;
`else
  assign w_first_psum = {DWIDTH{1'b0}};
`endif

  assign w_start_job   = (r_state == S_IDLE) && i_start;
  assign w_is_last     = (r_ch_cnt == (r_ich - CH_ONE));
  assign w_is_last_pix = (r_pix_cnt == (r_npix - PIX_ONE));
  // Tree still busy with a beat issued fewer than LAT cycles ago.
  assign w_spacing_ok  = ~|r_vld_sr[LAT-2:0];
  // A last beat needs the result register to be free by its capture: no
  // capture may still be pending, and any held result must leave this cycle.
  assign w_slot_ok     = (~|r_last_sr) && (!r_res_valid || i_res_ready);
  assign w_pe_ready    = (r_state == S_RUN) && w_spacing_ok && (!w_is_last || w_slot_ok);
  assign w_accept      = i_pe_valid && w_pe_ready;
  assign w_capture     = r_vld_sr[LAT-1] && r_last_sr[LAT-1];
  assign w_res_hs      = r_res_valid && i_res_ready;

  assign o_pe_ready     = w_pe_ready;
  assign o_tree_psum_in = (r_ch_cnt == {CH_W{1'b0}}) ? w_first_psum : i_tree_psum_out;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_res_valid    = r_res_valid;
  assign o_res_data     = r_res_data;

  // Next-state logic for the job sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = (i_cfg_npix == {PIX_W{1'b0}}) ? S_DONE : S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_accept && w_is_last && w_is_last_pix) begin
          w_next_state = S_DRAIN;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DRAIN: begin
        // Final result has been captured and is leaving this cycle.
        if (w_res_hs && (~|r_last_sr)) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_DRAIN;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == S_RUN) || (w_next_state == S_DRAIN);
      r_done  <= (w_next_state == S_DONE);
    end
  end

  // Job configuration and channel/pixel counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ich     <= {CH_W{1'b0}};
      r_npix    <= {PIX_W{1'b0}};
      r_ch_cnt  <= {CH_W{1'b0}};
      r_pix_cnt <= {PIX_W{1'b0}};
`ifdef PSUM_ACC_CTRL_BIAS_EN
      r_bias    <= {DWIDTH{1'b0}};
`endif
    end else if (w_start_job) begin
      r_ich     <= (i_cfg_ich == {CH_W{1'b0}}) ? CH_ONE : i_cfg_ich;
      r_npix    <= i_cfg_npix;
      r_ch_cnt  <= {CH_W{1'b0}};
      r_pix_cnt <= {PIX_W{1'b0}};
`ifdef PSUM_ACC_CTRL_BIAS_EN
      r_bias    <= i_cfg_bias;
`endif
    end else if (w_accept) begin
      if (w_is_last) begin
        r_ch_cnt  <= {CH_W{1'b0}};
        r_pix_cnt <= r_pix_cnt + PIX_ONE;
      end else begin
        r_ch_cnt  <= r_ch_cnt + CH_ONE;
      end
    end
  end

  // In-flight beat tracking through the adder tree latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld_sr  <= {LAT{1'b0}};
      r_last_sr <= {LAT{1'b0}};
    end else begin
      r_vld_sr  <= {r_vld_sr[LAT-2:0], w_accept};
      r_last_sr <= {r_last_sr[LAT-2:0], w_accept && w_is_last};
    end
  end

  // Result register: capture wins over handshake, though the last-beat
  // gating keeps the two from coinciding.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= {DWIDTH{1'b0}};
    end else if (w_capture) begin
      r_res_valid <= 1'b1;
      r_res_data  <= i_tree_psum_out;
    end else if (w_res_hs) begin
      r_res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_acc_ctrl.sv
module tb_psum_acc_ctrl;

  localparam int DW = 25;

  logic          clk;
  logic          rst;
  logic          start;
  logic [7:0]    cfg_ich;
  logic [15:0]   cfg_npix;
  logic          pe_valid;
  logic          res_ready;
  logic [DW-1:0] row;
  logic [DW-1:0] p1;
  logic [DW-1:0] p2;
`ifdef PSUM_ACC_CTRL_BIAS_EN
  logic [DW-1:0] cfg_bias;
`endif

  logic          o_busy;
  logic          o_done;
  logic          o_pe_ready;
  logic [DW-1:0] o_tree_psum_in;
  logic          o_res_valid;
  logic [DW-1:0] o_res_data;

  int n_assert = 0;
  int n_fail   = 0;
  logic prev_acc;

  psum_acc_ctrl dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_cfg_ich       (cfg_ich),
    .i_cfg_npix      (cfg_npix),
`ifdef PSUM_ACC_CTRL_BIAS_EN
    .i_cfg_bias      (cfg_bias),
`endif
    .o_busy          (o_busy),
    .o_done          (o_done),
    .i_pe_valid      (pe_valid),
    .o_pe_ready      (o_pe_ready),
    .i_tree_psum_out (p2),
    .o_tree_psum_in  (o_tree_psum_in),
    .o_res_valid     (o_res_valid),
    .i_res_ready     (res_ready),
    .o_res_data      (o_res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage adder tree model: output holds psum_in + row sum of the beat
  // accepted two cycles earlier, and keeps it until the next beat arrives.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      if (pe_valid && o_pe_ready) p1 <= o_tree_psum_in + row;
      p2 <= p1;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_ich = 8'd0; cfg_npix = 16'd0;
    pe_valid = 1'b0; res_ready = 1'b0; row = '0; prev_acc = 1'b0;
`ifdef PSUM_ACC_CTRL_BIAS_EN
    cfg_bias = '0;
`endif
    step(); step(); #1;
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_done", o_done, 1'b0);
    chk1("rst_pe_ready", o_pe_ready, 1'b0);
    chk1("rst_res_valid", o_res_valid, 1'b0);
    chkd("rst_res_data", o_res_data, 25'd0);
    step(); rst = 1'b0;

    // Basic run: ich=3, npix=1, row sums 10,20,30
    step(); start = 1'b1; cfg_ich = 8'd3; cfg_npix = 16'd1; res_ready = 1'b1; #1;
    chk1("t1_idle_busy", o_busy, 1'b0);
    chk1("t1_idle_ready", o_pe_ready, 1'b0);
    step(); start = 1'b0; pe_valid = 1'b1; row = 25'd10; #1;
    chk1("t1_busy", o_busy, 1'b1);
    chk1("t1_ready0", o_pe_ready, 1'b1);
    chkd("t1_psum_in0", o_tree_psum_in, 25'd0);
    step(); row = 25'd20; #1;
    chk1("t1_gap0", o_pe_ready, 1'b0);
    step(); #1;
    chk1("t1_ready1", o_pe_ready, 1'b1);
    chkd("t1_psum_in1", o_tree_psum_in, 25'd10);
    step(); row = 25'd30; #1;
    chk1("t1_gap1", o_pe_ready, 1'b0);
    step(); #1;
    chk1("t1_ready2", o_pe_ready, 1'b1);
    chkd("t1_psum_in2", o_tree_psum_in, 25'd30);
    step(); pe_valid = 1'b0; #1;
    chk1("t1_drain_ready", o_pe_ready, 1'b0);
    chk1("t1_res_early0", o_res_valid, 1'b0);
    step(); #1;
    chk1("t1_res_early1", o_res_valid, 1'b0);
    step(); #1;
    chk1("t1_res_valid", o_res_valid, 1'b1);
    chkd("t1_res_data", o_res_data, 25'd60);
    chk1("t1_done_early", o_done, 1'b0);
    step(); #1;
    chk1("t1_done", o_done, 1'b1);
    chk1("t1_done_busy", o_busy, 1'b0);
    chk1("t1_res_cleared", o_res_valid, 1'b0);
    step(); #1;
    chk1("t1_done_pulse", o_done, 1'b0);

    // Issue spacing: ich=4, pe_valid held high, row sum 5 per beat
    step(); start = 1'b1; cfg_ich = 8'd4; cfg_npix = 16'd1; res_ready = 1'b1; #1;
    prev_acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(); start = 1'b0; pe_valid = 1'b1; row = 25'd5; #1;
      chk1("t2_ready", o_pe_ready, ((i % 2) == 0) && (i < 7));
      if (((i % 2) == 0) && (i < 7)) chkd("t2_psum_in", o_tree_psum_in, 25'(5 * (i / 2)));
      if (prev_acc) chk1("t2_no_back2back", o_pe_ready, 1'b0);
      prev_acc = pe_valid && o_pe_ready;
    end
    step(); pe_valid = 1'b0; #1;
    chk1("t2_res_early", o_res_valid, 1'b0);
    step(); #1;
    chk1("t2_res_valid", o_res_valid, 1'b1);
    chkd("t2_res_data", o_res_data, 25'd20);
    step(); #1;
    chk1("t2_done", o_done, 1'b1);

    // Backpressure: npix=2, ich=1, rows 7 then 9, res_ready low
    step(); start = 1'b1; cfg_ich = 8'd1; cfg_npix = 16'd2; res_ready = 1'b0; #1;
    step(); start = 1'b0; pe_valid = 1'b1; row = 25'd7; #1;
    chk1("t3_ready_a", o_pe_ready, 1'b1);
    chkd("t3_psum_in_a", o_tree_psum_in, 25'd0);
    step(); row = 25'd9; #1;
    chk1("t3_gap", o_pe_ready, 1'b0);
    step(); #1;
    chk1("t3_pending_capture", o_pe_ready, 1'b0);
    step(); #1;
    chk1("t3_res_valid_a", o_res_valid, 1'b1);
    chkd("t3_res_data_a", o_res_data, 25'd7);
    chk1("t3_blocked0", o_pe_ready, 1'b0);
    step(); #1;
    chk1("t3_blocked1", o_pe_ready, 1'b0);
    chk1("t3_held", o_res_valid, 1'b1);
    chkd("t3_held_data", o_res_data, 25'd7);
    step(); res_ready = 1'b1; #1;
    chk1("t3_ready_b", o_pe_ready, 1'b1);
    chkd("t3_psum_in_b", o_tree_psum_in, 25'd0);
    step(); pe_valid = 1'b0; res_ready = 1'b0; #1;
    chk1("t3_res_taken", o_res_valid, 1'b0);
    step(); #1;
    chk1("t3_res_early_b", o_res_valid, 1'b0);
    step(); #1;
    chk1("t3_res_valid_b", o_res_valid, 1'b1);
    chkd("t3_res_data_b", o_res_data, 25'd9);
    chk1("t3_no_done", o_done, 1'b0);
    step(); res_ready = 1'b1; #1;
    chk1("t3_busy_drain", o_busy, 1'b1);
    step(); #1;
    chk1("t3_done", o_done, 1'b1);
    chk1("t3_res_final", o_res_valid, 1'b0);

    // Degenerate npix=0
    step(); start = 1'b1; cfg_ich = 8'd2; cfg_npix = 16'd0; #1;
    chk1("t4_ready", o_pe_ready, 1'b0);
    step(); start = 1'b0; #1;
    chk1("t4_done", o_done, 1'b1);
    chk1("t4_busy", o_busy, 1'b0);
    chk1("t4_ready_done", o_pe_ready, 1'b0);
    step(); #1;
    chk1("t4_done_pulse", o_done, 1'b0);

    // Degenerate ich=0 behaves as ich=1
    step(); start = 1'b1; cfg_ich = 8'd0; cfg_npix = 16'd1; res_ready = 1'b1; #1;
    step(); start = 1'b0; pe_valid = 1'b1; row = 25'd11; #1;
    chk1("t5_ready", o_pe_ready, 1'b1);
    chkd("t5_psum_in", o_tree_psum_in, 25'd0);
    step(); pe_valid = 1'b0; #1;
    chk1("t5_drain_ready", o_pe_ready, 1'b0);
    step(); #1;
    chk1("t5_res_early", o_res_valid, 1'b0);
    step(); #1;
    chk1("t5_res_valid", o_res_valid, 1'b1);
    chkd("t5_res_data", o_res_data, 25'd11);
    step(); #1;
    chk1("t5_done", o_done, 1'b1);

    // Reset during DRAIN, then a fresh job
    step(); start = 1'b1; cfg_ich = 8'd1; cfg_npix = 16'd1; res_ready = 1'b0; #1;
    step(); start = 1'b0; pe_valid = 1'b1; row = 25'd3; #1;
    chk1("t6_ready", o_pe_ready, 1'b1);
    step(); pe_valid = 1'b0; #1;
    chk1("t6_busy_drain", o_busy, 1'b1);
    step(); #1;
    step(); #1;
    chk1("t6_res_valid", o_res_valid, 1'b1);
    step(); rst = 1'b1; #1;
    chk1("t6_rst_res_valid", o_res_valid, 1'b0);
    chk1("t6_rst_busy", o_busy, 1'b0);
    chk1("t6_rst_done", o_done, 1'b0);
    chk1("t6_rst_ready", o_pe_ready, 1'b0);
    step(); rst = 1'b0; res_ready = 1'b1; #1;
    step(); start = 1'b1; cfg_ich = 8'd2; cfg_npix = 16'd1; #1;
    step(); start = 1'b0; pe_valid = 1'b1; row = 25'd4; #1;
    chk1("t6_new_ready0", o_pe_ready, 1'b1);
    chkd("t6_new_psum_in0", o_tree_psum_in, 25'd0);
    step(); row = 25'd6; #1;
    chk1("t6_new_gap", o_pe_ready, 1'b0);
    step(); #1;
    chk1("t6_new_ready1", o_pe_ready, 1'b1);
    chkd("t6_new_psum_in1", o_tree_psum_in, 25'd4);
    step(); pe_valid = 1'b0; #1;
    step(); #1;
    chk1("t6_new_res_early", o_res_valid, 1'b0);
    step(); #1;
    chk1("t6_new_res_valid", o_res_valid, 1'b1);
    chkd("t6_new_res_data", o_res_data, 25'd10);
    step(); #1;
    chk1("t6_new_done", o_done, 1'b1);

`ifdef PSUM_ACC_CTRL_BIAS_EN
    // Bias: -5 + 7 + 8 = 10
    step(); start = 1'b1; cfg_ich = 8'd2; cfg_npix = 16'd1; cfg_bias = 25'h1FFFFFB; res_ready = 1'b1; #1;
    step(); start = 1'b0; pe_valid = 1'b1; row = 25'd7; #1;
    chkd("t7_psum_in0", o_tree_psum_in, 25'h1FFFFFB);
    step(); row = 25'd8; #1;
    step(); #1;
    chkd("t7_psum_in1", o_tree_psum_in, 25'd2);
    step(); pe_valid = 1'b0; #1;
    step(); #1;
    step(); #1;
    chk1("t7_res_valid", o_res_valid, 1'b1);
    chkd("t7_res_data", o_res_data, 25'd10);
    step(); #1;
    chk1("t7_done", o_done, 1'b1);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
